// File: rtl/router_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | router_pkg                                                                 |
// | Shared constants and types for the router per-port packet FIFO.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package router_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  // Header word layout is {len[LEN_MSB:LEN_LSB], addr[ADDR_W-1:0]}
  localparam int LEN_MSB = DEFAULT_DATA_W - 1;
  localparam int LEN_LSB = 2;
  localparam int ADDR_W  = 2;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/router_pkt_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | router_pkt_fifo_if                                                         |
// | Write/read handshake and status bundle of one router output-port FIFO.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface router_pkt_fifo_if #(
  parameter int DATA_W = router_pkg::DEFAULT_DATA_W,
  parameter int DEPTH  = router_pkg::DEFAULT_DEPTH
);

  logic                       write_enb;
  logic                       lfd_state;
  logic [DATA_W-1:0]          data_in;
  logic                       read_enb;
  logic [DATA_W-1:0]          data_out;
  logic                       full;
  logic                       empty;
  logic                       almost_full;
  logic                       almost_empty;
  logic                       overflow;
  logic                       pkt_done;
  logic                       framing_err;
  logic [$clog2(DEPTH+1)-1:0] pkts_stored;

  modport master (
    output write_enb, lfd_state, data_in, read_enb,
    input  data_out, full, empty, almost_full, almost_empty,
    input  overflow, pkt_done, framing_err, pkts_stored
  );

  modport slave (
    input  write_enb, lfd_state, data_in, read_enb,
    output data_out, full, empty, almost_full, almost_empty,
    output overflow, pkt_done, framing_err, pkts_stored
  );

endinterface
`default_nettype wire

// File: rtl/router_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | router_fifo_mem                                                            |
// | Dual-port register array: synchronous write, combinational indexed read.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module router_fifo_mem #(
  parameter int WIDTH  = router_pkg::DEFAULT_DATA_W + 1,
  parameter int DEPTH  = router_pkg::DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  wire logic              clock,
  input  wire logic              write_en,
  input  wire logic [ADDR_W-1:0] write_addr,
  input  wire logic [WIDTH-1:0]  write_data,
  input  wire logic [ADDR_W-1:0] read_addr,
  output logic      [WIDTH-1:0]  read_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (write_en) begin
      r_mem[write_addr] <= write_data;
    end
  end

  assign read_data = r_mem[read_addr];

endmodule
`default_nettype wire

// File: rtl/router_pkt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | router_pkt_fifo                                                            |
// | Packet-aware per-port FIFO: header-tagged storage, level flags, framing.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  wire logic        clock,
  input  wire logic        resetn,
  input  wire logic        soft_reset,
  router_pkt_fifo_if.slave bus
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = $clog2(DEPTH + 1);
  localparam int C_REM_W = DATA_W - 1;
  localparam int C_LEN_W = DATA_W - LEN_LSB;

  localparam logic [C_PTR_W-1:0] C_LAST_PTR  = C_PTR_W'(DEPTH - 1);
  localparam logic [C_CNT_W-1:0] C_DEPTH_CNT = C_CNT_W'(DEPTH);
  localparam logic [C_CNT_W-1:0] C_AFULL_TH  = C_CNT_W'(AFULL_TH);
  localparam logic [C_CNT_W-1:0] C_AEMPTY_TH = C_CNT_W'(AEMPTY_TH);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
  localparam logic [C_REM_W-1:0] C_REM_ONE   = C_REM_W'(1);

  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_CNT_W-1:0] r_count;
  logic [C_CNT_W-1:0] r_pkts;
  logic               r_overflow;

  rd_state_t          r_state;
  logic [C_REM_W-1:0] r_rem;
  logic [DATA_W-1:0]  r_data_out;
  logic               r_pkt_done;
  logic               r_framing_err;

  logic               w_full;
  logic               w_empty;
  logic               w_wr_acc;
  logic               w_rd_acc;
  logic               w_pkt_inc;
  logic               w_pkt_dec;
  logic [DATA_W:0]    w_rd_word;
  logic               w_rd_hdr;
  logic [C_LEN_W-1:0] w_len;
  logic [C_REM_W-1:0] w_rem_load;

  function automatic logic [C_PTR_W-1:0] f_ptr_inc(input logic [C_PTR_W-1:0] ptr);
    return (ptr == C_LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  router_fifo_mem #(
    .WIDTH  (DATA_W + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (C_PTR_W)
  ) u_mem (
    .clock      (clock),
    .write_en   (w_wr_acc && !soft_reset),
    .write_addr (r_wr_ptr),
    .write_data ({bus.lfd_state, bus.data_in}),
    .read_addr  (r_rd_ptr),
    .read_data  (w_rd_word)
  );

  // Full/empty come from the registered count, so a read never frees a slot
  // for a write in the same cycle.
  assign w_full     = (r_count == C_DEPTH_CNT);
  assign w_empty    = (r_count == '0);
  assign w_wr_acc   = bus.write_enb && !w_full;
  assign w_rd_acc   = bus.read_enb && !w_empty;
  assign w_pkt_inc  = w_wr_acc && bus.lfd_state;
  assign w_pkt_dec  = w_rd_acc && w_rd_hdr;

  assign w_rd_hdr   = w_rd_word[DATA_W];
  assign w_len      = w_rd_word[DATA_W-1:LEN_LSB];
  // Payload words plus the trailing parity word; max len + 1 fits in C_REM_W.
  assign w_rem_load = C_REM_W'(w_len) + C_REM_W'(1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pkts     <= '0;
      r_overflow <= 1'b0;
    end else if (soft_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_pkts     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= bus.write_enb && w_full;

      if (w_wr_acc) begin
        r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end

      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase

      case ({w_pkt_inc, w_pkt_dec})
        2'b10:   r_pkts <= r_pkts + C_CNT_ONE;
        2'b01:   r_pkts <= r_pkts - C_CNT_ONE;
        default: r_pkts <= r_pkts;
      endcase
    end
  end

  // Read-side framing tracker; advances only on accepted reads.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_rem         <= '0;
      r_data_out    <= '0;
      r_pkt_done    <= 1'b0;
      r_framing_err <= 1'b0;
    end else if (soft_reset) begin
      r_state       <= IDLE;
      r_rem         <= '0;
      r_data_out    <= '0;
      r_pkt_done    <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      r_pkt_done    <= 1'b0;
      r_framing_err <= 1'b0;
      if (w_rd_acc) begin
        r_data_out <= w_rd_word[DATA_W-1:0];
        case (r_state)
          IDLE: begin
            if (w_rd_hdr) begin
              r_rem   <= w_rem_load;
              r_state <= PAYLOAD;
            end else begin
              r_framing_err <= 1'b1;
            end
          end
          PAYLOAD: begin
            if (w_rd_hdr) begin
              // A header inside a packet restarts framing from that header.
              r_framing_err <= 1'b1;
              r_rem         <= w_rem_load;
            end else if (r_rem == C_REM_ONE) begin
              r_pkt_done <= 1'b1;
              r_rem      <= '0;
              r_state    <= IDLE;
            end else begin
              r_rem <= r_rem - C_REM_ONE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_out     = r_data_out;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= C_AFULL_TH);
  assign bus.almost_empty = (r_count <= C_AEMPTY_TH);
  assign bus.overflow     = r_overflow;
  assign bus.pkt_done     = r_pkt_done;
  assign bus.framing_err  = r_framing_err;
  assign bus.pkts_stored  = r_pkts;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_router_pkt_fifo                                                         |
// | Directed, table-driven self-checking bench for router_pkt_fifo.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_router_pkt_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int NVEC   = 29;

  logic clock;
  logic resetn;
  logic soft_reset;

  int n_checks = 0;
  int n_fail   = 0;

  router_pkt_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  router_pkt_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_TH  (DEPTH - 2),
    .AEMPTY_TH (2)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       we;
    logic       lfd;
    logic [7:0] din;
    logic       re;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       done;
    logic       ferr;
    logic [4:0] pkts;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(logic we, logic lfd, logic [7:0] din, logic re,
                              logic [7:0] dout, logic full, logic empty, logic af,
                              logic ae, logic ovf, logic done, logic ferr,
                              logic [4:0] pkts);
    vec_t v;
    v.we = we; v.lfd = lfd; v.din = din; v.re = re;
    v.dout = dout; v.full = full; v.empty = empty; v.af = af; v.ae = ae;
    v.ovf = ovf; v.done = done; v.ferr = ferr; v.pkts = pkts;
    return v;
  endfunction

  function automatic logic [19:0] obs();
    return {bus.data_out, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
            bus.overflow, bus.pkt_done, bus.framing_err, bus.pkts_stored};
  endfunction

  function automatic logic [7:0] sval(int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic we, logic lfd, logic [7:0] din, logic re);
    bus.write_enb = we;
    bus.lfd_state = lfd;
    bus.data_in   = din;
    bus.read_enb  = re;
    @(posedge clock);
    #1;
  endtask

  initial begin
    clock         = 1'b0;
    resetn        = 1'b0;
    soft_reset    = 1'b1;
    bus.write_enb = 1'b0;
    bus.lfd_state = 1'b0;
    bus.data_in   = '0;
    bus.read_enb  = 1'b0;

    // Packet read, framing errors and simultaneous read/write at low level.
    //            we lfd din    re  dout   f  e  af ae ov dn fe pkts
    vecs[0]  = mk(1, 1, 8'h0D, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 5'd1);
    vecs[1]  = mk(1, 0, 8'hA1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 5'd1);
    vecs[2]  = mk(1, 0, 8'hA2, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 5'd1);
    vecs[3]  = mk(1, 0, 8'hA3, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 5'd1);
    vecs[4]  = mk(1, 0, 8'h5E, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 5'd1);
    vecs[5]  = mk(0, 0, 8'h00, 1, 8'h0D, 0, 0, 0, 0, 0, 0, 0, 5'd0);
    vecs[6]  = mk(0, 0, 8'h00, 1, 8'hA1, 0, 0, 0, 0, 0, 0, 0, 5'd0);
    vecs[7]  = mk(0, 0, 8'h00, 1, 8'hA2, 0, 0, 0, 1, 0, 0, 0, 5'd0);
    vecs[8]  = mk(0, 0, 8'h00, 1, 8'hA3, 0, 0, 0, 1, 0, 0, 0, 5'd0);
    vecs[9]  = mk(0, 0, 8'h00, 1, 8'h5E, 0, 1, 0, 1, 0, 1, 0, 5'd0);
    vecs[10] = mk(0, 0, 8'h00, 0, 8'h5E, 0, 1, 0, 1, 0, 0, 0, 5'd0);
    vecs[11] = mk(0, 0, 8'h00, 1, 8'h5E, 0, 1, 0, 1, 0, 0, 0, 5'd0);
    vecs[12] = mk(1, 1, 8'h0A, 0, 8'h5E, 0, 0, 0, 1, 0, 0, 0, 5'd1);
    vecs[13] = mk(1, 0, 8'hB1, 0, 8'h5E, 0, 0, 0, 1, 0, 0, 0, 5'd1);
    vecs[14] = mk(1, 1, 8'h06, 0, 8'h5E, 0, 0, 0, 0, 0, 0, 0, 5'd2);
    vecs[15] = mk(1, 0, 8'hC1, 0, 8'h5E, 0, 0, 0, 0, 0, 0, 0, 5'd2);
    vecs[16] = mk(1, 0, 8'hC2, 0, 8'h5E, 0, 0, 0, 0, 0, 0, 0, 5'd2);
    vecs[17] = mk(0, 0, 8'h00, 1, 8'h0A, 0, 0, 0, 0, 0, 0, 0, 5'd1);
    vecs[18] = mk(0, 0, 8'h00, 1, 8'hB1, 0, 0, 0, 0, 0, 0, 0, 5'd1);
    vecs[19] = mk(0, 0, 8'h00, 1, 8'h06, 0, 0, 0, 1, 0, 0, 1, 5'd0);
    vecs[20] = mk(0, 0, 8'h00, 1, 8'hC1, 0, 0, 0, 1, 0, 0, 0, 5'd0);
    vecs[21] = mk(0, 0, 8'h00, 1, 8'hC2, 0, 1, 0, 1, 0, 1, 0, 5'd0);
    vecs[22] = mk(1, 0, 8'h33, 0, 8'hC2, 0, 0, 0, 1, 0, 0, 0, 5'd0);
    vecs[23] = mk(0, 0, 8'h00, 1, 8'h33, 0, 1, 0, 1, 0, 0, 1, 5'd0);
    vecs[24] = mk(0, 0, 8'h00, 0, 8'h33, 0, 1, 0, 1, 0, 0, 0, 5'd0);
    vecs[25] = mk(1, 0, 8'h44, 1, 8'h33, 0, 0, 0, 1, 0, 0, 0, 5'd0);
    vecs[26] = mk(1, 0, 8'h55, 1, 8'h44, 0, 0, 0, 1, 0, 0, 1, 5'd0);
    vecs[27] = mk(0, 0, 8'h00, 1, 8'h55, 0, 1, 0, 1, 0, 0, 1, 5'd0);
    vecs[28] = mk(0, 0, 8'h00, 0, 8'h55, 0, 1, 0, 1, 0, 0, 0, 5'd0);

    // Reset with soft_reset also asserted, then release both.
    repeat (2) @(posedge clock);
    #1;
    chk("in_reset", 32'(obs()), 32'({8'h00, 7'b0101000, 5'd0}));
    resetn = 1'b1;
    @(posedge clock);
    #1;
    soft_reset = 1'b0;
    @(posedge clock);
    #1;
    chk("after_reset", 32'(obs()), 32'({8'h00, 7'b0101000, 5'd0}));

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].we, vecs[i].lfd, vecs[i].din, vecs[i].re);
      chk($sformatf("vec%0d", i), 32'(obs()),
          32'({vecs[i].dout, vecs[i].full, vecs[i].empty, vecs[i].af, vecs[i].ae,
               vecs[i].ovf, vecs[i].done, vecs[i].ferr, vecs[i].pkts}));
    end

    // Fill to full, then one write too many.
    for (int k = 1; k <= DEPTH; k++) begin
      drive(1'b1, 1'b0, 8'(8'h40 + k - 1), 1'b0);
      chk($sformatf("fill%0d_flags", k),
          32'({bus.full, bus.almost_full, bus.empty, bus.overflow}),
          32'({k == DEPTH, k >= DEPTH - 2, 1'b0, 1'b0}));
    end
    drive(1'b1, 1'b0, 8'hFF, 1'b0);
    chk("overflow_pulse", 32'({bus.overflow, bus.full}), 32'(2'b11));
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("overflow_clear", 32'({bus.overflow, bus.full}), 32'(2'b01));
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      chk($sformatf("drain%0d_data", k), 32'(bus.data_out), 32'(8'(8'h40 + k)));
    end
    chk("drain_empty", 32'({bus.empty, bus.full}), 32'(2'b10));

    // Streaming with simultaneous read/write at count 8; pointers wrap.
    begin
      int wi = 0;
      int ri = 0;
      for (int k = 0; k < 8; k++) begin
        drive(1'b1, 1'b0, sval(wi), 1'b0);
        wi++;
      end
      for (int k = 0; k < 40; k++) begin
        drive(1'b1, 1'b0, sval(wi), 1'b1);
        wi++;
        chk($sformatf("stream%0d", k),
            32'({bus.data_out, bus.full, bus.empty, bus.almost_full, bus.almost_empty}),
            32'({sval(ri), 4'b0000}));
        ri++;
      end
      for (int k = 0; k < 8; k++) begin
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk($sformatf("stream_drain%0d", k), 32'(bus.data_out), 32'(sval(ri)));
        ri++;
      end
      chk("stream_empty", 32'(bus.empty), 32'(1));
    end

    // soft_reset in the middle of a packet, with a competing write.
    drive(1'b1, 1'b1, 8'h0D, 1'b0);
    drive(1'b1, 1'b0, 8'hA1, 1'b0);
    drive(1'b1, 1'b0, 8'hA2, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("pre_soft_reset", 32'({bus.data_out, bus.empty, bus.pkts_stored}),
        32'({8'hA1, 1'b0, 5'd0}));
    soft_reset = 1'b1;
    drive(1'b1, 1'b1, 8'h77, 1'b0);
    soft_reset = 1'b0;
    chk("soft_reset", 32'(obs()), 32'({8'h00, 7'b0101000, 5'd0}));
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("soft_reset_no_write", 32'({bus.empty, bus.pkts_stored}), 32'({1'b1, 5'd0}));
    drive(1'b1, 1'b0, 8'h55, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_soft_reset_idle", 32'(obs()), 32'({8'h55, 7'b0101001, 5'd0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
